// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master: FSM state encoding,
// CPOL/CPHA mode encoding and the sample-edge rule.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // {cpol, cpha}
  localparam logic [1:0] MODE_0 = 2'd0;
  localparam logic [1:0] MODE_1 = 2'd1;
  localparam logic [1:0] MODE_2 = 2'd2;
  localparam logic [1:0] MODE_3 = 2'd3;

  // CPHA=0 samples on the rising SCLK edge, CPHA=1 on the falling edge,
  // whatever the idle level.
  function automatic logic sample_on_rise(input logic cpha);
    return !cpha;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host handshake plus SPI pins of the SPI master, grouped as one bundle.
interface spi_master_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic              cpol;
  logic              cpha;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              done;
  logic              sclk;
  logic              cs_;
  logic              mosi;
  logic              miso;
  logic              slave_start;

  modport master (
    input  start, cpol, cpha, tx_data, miso,
    output sclk, cs_, mosi, slave_start, rx_data, busy, done
  );

  modport slave (
    output start, cpol, cpha, tx_data, miso,
    input  sclk, cs_, mosi, slave_start, rx_data, busy, done
  );
endinterface

// File: rtl/spi_clk_divider.sv
// Half-period timebase: down-counter that pulses tick once every CLK_DIV
// cycles, re-phased by restart.
module spi_clk_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= RELOAD;
    end else if (restart || cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/spi_master.sv
// SPI master: one LSB-first full-duplex transfer per start, any CPOL/CPHA mode.
//
// state | meaning
// IDLE  | cs_ high, sclk tracks cpol input, waiting for start
// SETUP | cs_ low, first mosi bit presented, waiting one half-period
// SHIFT | sclk toggling, sampling miso and driving mosi
// HOLD  | sclk back at idle level, cs_ held low one more half-period
module spi_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input logic          clk,
  input logic          reset,
  spi_master_if.master bus
);
  import spi_pkg::*;

  localparam int TGL_W = $clog2(2*DATA_W + 1);
  localparam int SMP_W = $clog2(DATA_W + 1);
  localparam logic [TGL_W-1:0] LAST_TGL = TGL_W'(2*DATA_W - 1);
  localparam logic [SMP_W-1:0] ALL_SMP  = SMP_W'(DATA_W);

  state_t            state;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [TGL_W-1:0]  tgl_cnt;
  logic [SMP_W-1:0]  smp_cnt;
  logic              tick;
  logic              accept;
  logic              cpol_q;
  logic              cpha_q;
  logic              sclk_next;
  logic              sample_now;

  // A start coinciding with the done pulse is dropped, so frames are
  // always separated by at least one idle cycle.
  assign accept     = bus.start && (state == IDLE) && !bus.done;
  assign cpol_q     = (mode_q == MODE_2) || (mode_q == MODE_3);
  assign cpha_q     = (mode_q == MODE_1) || (mode_q == MODE_3);
  assign sclk_next  = ~bus.sclk;
  assign sample_now = (sclk_next == sample_on_rise(cpha_q));

  spi_clk_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk     (clk),
    .reset   (reset),
    .restart (accept),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      mode_q          <= MODE_0;
      tx_shift        <= '0;
      rx_shift        <= '0;
      tgl_cnt         <= '0;
      smp_cnt         <= '0;
      bus.sclk        <= 1'b0;
      bus.cs_         <= 1'b1;
      bus.mosi        <= 1'b0;
      bus.slave_start <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.rx_data     <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          bus.sclk <= bus.cpol;
          if (accept) begin
            mode_q          <= {bus.cpol, bus.cpha};
            tx_shift        <= bus.tx_data;
            rx_shift        <= '0;
            tgl_cnt         <= '0;
            smp_cnt         <= '0;
            bus.mosi        <= bus.tx_data[0];
            bus.cs_         <= 1'b0;
            bus.slave_start <= 1'b1;
            bus.busy        <= 1'b1;
            state           <= SETUP;
          end
        end
        // The tick that ends SETUP is also the first sclk toggle.
        SETUP, SHIFT: begin
          if (tick) begin
            bus.sclk <= sclk_next;
            tgl_cnt  <= tgl_cnt + TGL_W'(1);
            if (sample_now) begin
              rx_shift <= {bus.miso, rx_shift[DATA_W-1:1]};
              smp_cnt  <= smp_cnt + SMP_W'(1);
            end else if (smp_cnt != '0 && smp_cnt < ALL_SMP) begin
              tx_shift <= tx_shift >> 1;
              bus.mosi <= tx_shift[1];
            end
            state <= (tgl_cnt == LAST_TGL) ? HOLD : SHIFT;
          end
        end
        HOLD: begin
          if (tick) begin
            bus.sclk        <= cpol_q;
            bus.cs_         <= 1'b1;
            bus.slave_start <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.rx_data     <= rx_shift;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master (DATA_W=8, CLK_DIV=4) with a behavioural SPI slave.
`timescale 1ns/1ps
module tb_spi_master;
  localparam int LAT = 69;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] sl_tx = 8'h00;
  logic [7:0] sl_rx = 8'h00;
  logic [7:0] sl_sh = 8'h00;
  logic       sl_cpha = 1'b0;
  logic       miso_tie = 1'b0;
  int         sl_samples = 0;

  always #5 clk = ~clk;

  spi_master_if #(.DATA_W(8)) bus ();

  spi_master #(.DATA_W(8), .CLK_DIV(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.master)
  );

  // Slave: loads its word on cs_ fall, captures mosi on the sample edge and
  // advances miso on drive edges that follow a sample.
  initial begin : slave_model
    logic prev_cs;
    logic prev_sclk;
    prev_cs = 1'b1;
    prev_sclk = 1'b0;
    bus.miso = 1'b0;
    forever begin
      @(bus.cs_ or bus.sclk);
      if (prev_cs === 1'b1 && bus.cs_ === 1'b0) begin
        sl_sh = sl_tx;
        sl_rx = 8'h00;
        sl_samples = 0;
      end else if (bus.cs_ === 1'b0 && bus.sclk !== prev_sclk) begin
        if (bus.sclk === ~sl_cpha) begin
          sl_rx = {bus.mosi, sl_rx[7:1]};
          sl_samples++;
        end else if (sl_samples >= 1 && sl_samples < 8) begin
          sl_sh = sl_sh >> 1;
        end
      end
      bus.miso = miso_tie ? 1'b1 : sl_sh[0];
      prev_cs = bus.cs_;
      prev_sclk = bus.sclk;
    end
  end

  task automatic setup_xfer(input logic p, input logic h, input logic [7:0] tx, input logic [7:0] stx);
    bus.cpol = p;
    bus.cpha = h;
    bus.tx_data = tx;
    sl_tx = stx;
    sl_cpha = h;
    repeat (2) @(negedge clk);
  endtask

  // Drives start in the current cycle (cycle 0); lat is the cycle done is seen, -1 on timeout.
  task automatic run_xfer(output int lat);
    lat = -1;
    bus.start = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cs_, bus.sclk, bus.mosi} !== 3'b100) begin
      failures++; $display("FAIL reset_pins: got %b expected 100", {bus.cs_, bus.sclk, bus.mosi});
    end
    checks++;
    if ({bus.slave_start, bus.busy, bus.done} !== 3'b000) begin
      failures++; $display("FAIL reset_status: got %b expected 000", {bus.slave_start, bus.busy, bus.done});
    end
    checks++;
    if (bus.rx_data !== 8'h00) begin
      failures++; $display("FAIL reset_rx: got %h expected 00", bus.rx_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    setup_xfer(1'b0, 1'b0, 8'h33, 8'hCC);
    bus.start = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    checks++;
    if ({bus.sclk, bus.busy} !== 2'b11) begin
      failures++; $display("FAIL pre_reset_active: got %b expected 11", {bus.sclk, bus.busy});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.cs_, bus.sclk, bus.busy} !== 3'b100) begin
      failures++; $display("FAIL mid_reset_abort: got %b expected 100", {bus.cs_, bus.sclk, bus.busy});
    end
    checks++;
    if (bus.rx_data !== 8'h00) begin
      failures++; $display("FAIL mid_reset_rx: got %h expected 00", bus.rx_data);
    end
    bus.cpol = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.sclk !== 1'b1) begin
      failures++; $display("FAIL post_reset_idle_sclk: got %b expected 1", bus.sclk);
    end
    checks++;
    if (bus.rx_data !== 8'h00) begin
      failures++; $display("FAIL post_reset_rx: got %h expected 00", bus.rx_data);
    end
    setup_xfer(1'b1, 1'b0, 8'h96, 8'h69);
    run_xfer(lat);
    checks++;
    if (lat !== LAT) begin
      failures++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, LAT);
    end
    checks++;
    if (bus.rx_data !== 8'h69) begin
      failures++; $display("FAIL post_reset_rx_data: got %h expected 69", bus.rx_data);
    end
    checks++;
    if (sl_rx !== 8'h96) begin
      failures++; $display("FAIL post_reset_slave_rx: got %h expected 96", sl_rx);
    end
  endtask

  task automatic test_mode0();
    int   lat;
    logic busy_at_done;
    setup_xfer(1'b0, 1'b0, 8'hA5, 8'h3C);
    lat = -1;
    busy_at_done = 1'bx;
    bus.start = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (n == 10) begin
        checks++;
        if ({bus.slave_start, bus.cs_, bus.busy} !== 3'b101) begin
          failures++; $display("FAIL mode0_framing: got %b expected 101", {bus.slave_start, bus.cs_, bus.busy});
        end
      end
      if (bus.done === 1'b1) begin
        lat = n;
        busy_at_done = bus.busy;
        break;
      end
    end
    checks++;
    if (lat !== LAT) begin
      failures++; $display("FAIL mode0_latency: got %0d expected %0d", lat, LAT);
    end
    checks++;
    if (busy_at_done !== 1'b0) begin
      failures++; $display("FAIL mode0_busy_at_done: got %b expected 0", busy_at_done);
    end
    checks++;
    if (bus.rx_data !== 8'h3C) begin
      failures++; $display("FAIL mode0_rx: got %h expected 3c", bus.rx_data);
    end
    checks++;
    if (sl_rx !== 8'hA5) begin
      failures++; $display("FAIL mode0_mosi_bits: got %h expected a5", sl_rx);
    end
    checks++;
    if (sl_samples !== 8) begin
      failures++; $display("FAIL mode0_sample_edges: got %0d expected 8", sl_samples);
    end
  endtask

  task automatic test_modes();
    int   lat;
    logic p;
    logic h;
    for (int m = 1; m < 4; m++) begin
      p = m[1];
      h = m[0];
      setup_xfer(p, h, 8'h5A, 8'hC3);
      checks++;
      if (bus.sclk !== p || bus.cs_ !== 1'b1) begin
        failures++; $display("FAIL mode%0d_idle_before: got sclk=%b cs_=%b expected sclk=%b cs_=1", m, bus.sclk, bus.cs_, p);
      end
      run_xfer(lat);
      checks++;
      if (lat !== LAT || bus.cs_ !== 1'b1 || bus.sclk !== p) begin
        failures++; $display("FAIL mode%0d_end: got lat=%0d cs_=%b sclk=%b expected lat=%0d cs_=1 sclk=%b", m, lat, bus.cs_, bus.sclk, LAT, p);
      end
      checks++;
      if (bus.rx_data !== 8'hC3) begin
        failures++; $display("FAIL mode%0d_rx: got %h expected c3", m, bus.rx_data);
      end
      checks++;
      if (sl_rx !== 8'h5A) begin
        failures++; $display("FAIL mode%0d_slave_rx: got %h expected 5a", m, sl_rx);
      end
      checks++;
      if (sl_samples !== 8) begin
        failures++; $display("FAIL mode%0d_sample_edges: got %0d expected 8", m, sl_samples);
      end
    end
  endtask

  task automatic test_start_ignored();
    int ndone;
    int first;
    int second;
    setup_xfer(1'b0, 1'b0, 8'h0F, 8'hF0);
    ndone = 0;
    first = -1;
    second = -1;
    bus.start = 1'b1;
    for (int n = 1; n <= 75; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        if (first < 0) first = n;
      end
      if (n == 70) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          failures++; $display("FAIL start_at_done_ignored: got busy=%b expected 0", bus.busy);
        end
      end
      if (n == 71) begin
        checks++;
        if ({bus.busy, bus.cs_} !== 2'b10) begin
          failures++; $display("FAIL start_after_done_accepted: got %b expected 10", {bus.busy, bus.cs_});
        end
      end
      bus.start = (n == 10) || (first > 0 && (n == first || n == first + 1));
    end
    bus.start = 1'b0;
    checks++;
    if (ndone !== 1 || first !== LAT) begin
      failures++; $display("FAIL single_done: got count=%0d cycle=%0d expected count=1 cycle=%0d", ndone, first, LAT);
    end
    for (int n = 76; n <= 300; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        second = n;
        break;
      end
    end
    checks++;
    if (second !== 70 + LAT) begin
      failures++; $display("FAIL second_done_cycle: got %0d expected %0d", second, 70 + LAT);
    end
    checks++;
    if (bus.rx_data !== 8'hF0) begin
      failures++; $display("FAIL second_rx: got %h expected f0", bus.rx_data);
    end
  endtask

  task automatic test_back_to_back();
    int         lat1;
    int         lat2;
    logic [7:0] rx1;
    logic [7:0] slv1;
    logic       cs69;
    logic       cs70;
    miso_tie = 1'b1;
    setup_xfer(1'b0, 1'b0, 8'hFF, 8'h00);
    run_xfer(lat1);
    rx1 = bus.rx_data;
    slv1 = sl_rx;
    cs69 = bus.cs_;
    bus.tx_data = 8'h00;
    bus.start = 1'b1;
    @(negedge clk);
    cs70 = bus.cs_;
    run_xfer(lat2);
    checks++;
    if (lat1 !== LAT || lat2 !== LAT) begin
      failures++; $display("FAIL b2b_latency: got %0d,%0d expected %0d,%0d", lat1, lat2, LAT, LAT);
    end
    checks++;
    if ({cs69, cs70} !== 2'b11) begin
      failures++; $display("FAIL b2b_cs_gap: got %b expected 11", {cs69, cs70});
    end
    checks++;
    if (rx1 !== 8'hFF || bus.rx_data !== 8'hFF) begin
      failures++; $display("FAIL b2b_rx: got %h,%h expected ff,ff", rx1, bus.rx_data);
    end
    checks++;
    if (slv1 !== 8'hFF || sl_rx !== 8'h00) begin
      failures++; $display("FAIL b2b_slave_rx: got %h,%h expected ff,00", slv1, sl_rx);
    end
    miso_tie = 1'b0;
  endtask

  task automatic test_mid_change();
    int   lat;
    logic sclk_end;
    setup_xfer(1'b1, 1'b1, 8'h81, 8'h7E);
    lat = -1;
    sclk_end = 1'bx;
    bus.start = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (n == 20) begin
        bus.cpol = 1'b0;
        bus.cpha = 1'b0;
        bus.tx_data = 8'h00;
      end
      if (bus.done === 1'b1) begin
        lat = n;
        sclk_end = bus.sclk;
        break;
      end
    end
    checks++;
    if (lat !== LAT) begin
      failures++; $display("FAIL mid_change_latency: got %0d expected %0d", lat, LAT);
    end
    checks++;
    if (bus.rx_data !== 8'h7E) begin
      failures++; $display("FAIL mid_change_rx: got %h expected 7e", bus.rx_data);
    end
    checks++;
    if (sl_rx !== 8'h81) begin
      failures++; $display("FAIL mid_change_mosi: got %h expected 81", sl_rx);
    end
    checks++;
    if (sl_samples !== 8 || sclk_end !== 1'b1) begin
      failures++; $display("FAIL mid_change_edges: got samples=%0d sclk=%b expected samples=8 sclk=1", sl_samples, sclk_end);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.cpol = 1'b0;
    bus.cpha = 1'b0;
    bus.tx_data = 8'h00;
    test_reset();
    test_reset_mid();
    test_mode0();
    test_modes();
    test_start_ignored();
    test_back_to_back();
    test_mid_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Upstream stage of the SPI slave: it generates SCLK, CS_, MOSI and the slave_start qualifier, and samples MISO.
- Performs one full-duplex, LSB-first transfer of DATA_W bits per start request, in any of the four CPOL/CPHA modes.
- Uses the team's edge convention: when CPHA=0 data is sampled on the SCLK rising edge and driven on the falling edge; when CPHA=1 data is driven on rising and sampled on falling, independent of CPOL. CPOL sets only the idle level of SCLK.
- Runs from a single system clock. SCLK is derived by division.

Parameters:
- DATA_W, 8, transfer length in bits.
- CLK_DIV, 4, number of clk cycles per SCLK half-period. Minimum 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle transfer request; accepted only in IDLE.
- cpol  in  1  clock polarity; latched on accept.
- cpha  in  1  clock phase; latched on accept.
- tx_data  in  DATA_W  word to send; latched on accept.
- miso  in  1  serial data from the slave.
- sclk  out  1  SPI clock.
- cs_  out  1  chip select, active low.
- mosi  out  1  serial data to the slave.
- slave_start  out  1  high while a transfer is framed (cs_ low).
- rx_data  out  DATA_W  last received word.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle pulse at the end of a transfer.

Behaviour:
- Reset (async assert, sync release) sets sclk=0, cs_=1, mosi=0, slave_start=0, busy=0, done=0, rx_data=0, and the state to IDLE.
  - Reset mid-transfer aborts immediately. rx_data is not updated.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE:
  - sclk follows the cpol input, registered with 1 cycle delay.
  - cs_=1, busy=0.
  - start=1 at cycle 0 latches cpol, cpha and tx_data, then moves to SETUP.
- SETUP (entered at cycle 1):
  - cs_=0, slave_start=1, busy=1, mosi=tx_data[0].
  - The divider restarts.
  - After CLK_DIV cycles the state moves to SHIFT.
- SHIFT:
  - One sclk toggle every CLK_DIV cycles: toggle k occurs at cycle 1+k*CLK_DIV, for k=1..2*DATA_W.
  - A sample toggle is one whose direction is the sample edge for the latched cpha. On each sample toggle: rx_shift = {miso, rx_shift[DATA_W-1:1]}; the sample counter increments.
  - A drive toggle is the other direction. On a drive toggle with sample count ≥1 and <DATA_W, tx_shift shifts right and mosi = the next bit. Drive toggles that occur before the first sample, or after the last one, leave mosi unchanged.
  - After toggle 2*DATA_W, sclk is back at the latched cpol and the state moves to HOLD.
- HOLD:
  - After CLK_DIV cycles, at cycle 1+(2*DATA_W+1)*CLK_DIV: cs_=1, slave_start=0, busy=0, done=1 (one cycle), rx_data=rx_shift. The state returns to IDLE.
- The start→done latency is (2*DATA_W+1)*CLK_DIV+1 cycles. For DATA_W=8, CLK_DIV=4 this is 69.
- start while busy is ignored; no queueing.
- If start occurs in the same cycle done is pulsed, it is ignored. A new start is accepted from the next cycle.
- Changes on the cpol, cpha or tx_data inputs during a transfer have no effect.
- Counter widths: $clog2(CLK_DIV) for the divider; $clog2(2*DATA_W+1) for toggles.

Decomposition:
- spi_pkg holds:
  - state enum {IDLE, SETUP, SHIFT, HOLD};
  - localparams for the mode encoding {cpol,cpha} 0..3;
  - function sample_on_rise(cpha) = !cpha.
- One sub-module, spi_clk_divider: parameter CLK_DIV, inputs clk/reset/restart, output tick (one-cycle pulse every CLK_DIV cycles).

Test Plan:
- Mode 0, CLK_DIV=4, tx_data=0xA5, a slave model preloaded with 0x3C:
  - mosi sampled on rising edges reads LSB-first 1,0,1,0,0,1,0,1;
  - rx_data=0x3C;
  - done pulses at cycle 69 with busy falling the same cycle.
- Modes 1, 2, 3, each with tx=0x5A and slave=0xC3:
  - rx_data=0xC3 and the slave captures 0x5A;
  - sclk idles at cpol before cs_ falls and after cs_ rises;
  - exactly 8 sample-edge transitions while cs_=0.
- start asserted again at cycles 10 and 69 during a transfer:
  - both ignored;
  - a single done;
  - start at cycle 70 is accepted.
- reset driven low at cycle 30 mid-transfer:
  - cs_=1, sclk=0, busy=0 immediately;
  - rx_data keeps its prior value;
  - after release, sclk follows cpol and a fresh transfer completes correctly.
- Back-to-back transfers 0xFF then 0x00, with miso tied to 1:
  - rx_data=0xFF both times;
  - cs_ high for at least 1 cycle between the two frames.
- Toggle cpol, cpha and tx_data mid-transfer:
  - current frame unaffected (rx and mosi match the latched values).
